ddr_arbiter: RTL
================

DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, meaning request address width ({bank[1:0], row[12:0], col[8:0]}).
REQ-002 SHALL have parameter REFI_CYCLES, default 1037, meaning clk133 cycles between refresh requests (7.8 us at 133 MHz).
REQ-003 SHALL have port clk133  input  1  meaning controller clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports disp_req, disp_urgent  input  1 each  meaning display read request and display FIFO near-empty.
REQ-006 SHALL have port disp_addr  input  ADDR_W  meaning display read address.
REQ-007 SHALL have ports disp_gnt, disp_done  output  1 each  meaning grant pulse and completion pulse to display.
REQ-008 SHALL have ports draw_req, draw_addr, draw_gnt, draw_done  meaning drawing write port; directions and widths match the display ports.
REQ-009 SHALL have ports ctl_valid, ctl_write, ctl_refresh  output  1 each  meaning command to DDR controller: valid, write (1) or read (0), refresh.
REQ-010 SHALL have port ctl_addr  output  ADDR_W  meaning command address.
REQ-011 SHALL have ports ctl_ready, ctl_done  input  1 each  meaning controller accepts command, and controller finished command (1-cycle pulse).
REQ-012 SHALL have ports busy, refresh_overrun  output  1 each  meaning arbiter not IDLE, and sticky refresh-debt overflow.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-014 IDLE: SHALL select by priority: pending refresh; then disp_req with disp_urgent; then round-robin between disp_req and draw_req (first after reset: display).
REQ-015 On selection: SHALL register ctl_valid=1, ctl_addr, ctl_write and ctl_refresh in the next cycle, pulse the matching gnt for 1 cycle, and enter ISSUE.
REQ-016 Refresh command: SHALL drive ctl_addr=0 and ctl_write=0.
REQ-017 Latency: request sampled in IDLE at cycle N SHALL give ctl_valid and gnt at N+1.
REQ-018 ISSUE: SHALL hold ctl_valid and all command fields stable until ctl_valid&&ctl_ready, then drop ctl_valid next cycle and enter WAIT.
REQ-019 WAIT: on ctl_done SHALL pulse the owner's done (none for refresh), update the round-robin pointer to the other requester, and return to IDLE.
REQ-020 Minimum of 1 IDLE cycle between commands; a request present with ctl_done SHALL be arbitrated in the following cycle.
REQ-021 Address SHALL be sampled only at selection; requesters hold req until gnt; req dropped before gnt SHALL be ignored.
REQ-022 ctl_done outside WAIT SHALL be ignored.
REQ-023 Refresh timer SHALL count down from REFI_CYCLES-1 and on reaching 0 increment a refresh debt counter (0..8) and reload.
REQ-024 Debt SHALL decrement on refresh command acceptance; simultaneous expiry and acceptance SHALL leave it unchanged.
REQ-025 Expiry at debt 8 SHALL saturate and set refresh_overrun until reset.

Reset
REQ-026 On rst_n low SHALL asynchronously enter IDLE; all outputs 0; debt 0; timer REFI_CYCLES-1; RR pointer at display.
REQ-027 Reset mid-command SHALL abandon it without a done pulse.

Configuration
REQ-028 With DDR_ARB_REFRESH_EN defined SHALL include the refresh timer, debt counter and refresh priority (REQ-023..025).
REQ-029 Without DDR_ARB_REFRESH_EN SHALL omit that logic and tie ctl_refresh and refresh_overrun to 0.

Structure
REQ-030 Shared package ddr_pkg SHALL hold the state encoding, requester IDs (REQ_DISP, REQ_DRAW, REQ_REFRESH) and the default REFI_CYCLES and ADDR_W.
REQ-031 Refresh timer and debt counter SHALL be sub-module ddr_refresh_timer, instantiated only under DDR_ARB_REFRESH_EN.

Verification
REQ-032 Only disp_req=1 with disp_addr=0x012345, ctl_ready=1 -> disp_gnt and ctl_valid at N+1, ctl_write=0, ctl_addr=0x012345; ctl_done -> disp_done for 1 cycle.
REQ-033 Both requesters continuously active, no urgent -> grants alternate display, draw, display, draw across 4 commands.
REQ-034 draw owner last, disp_urgent=1, both requesting -> display granted even when RR pointer favours draw.
REQ-035 REFI_CYCLES=16, requests idle -> ctl_refresh=1 command every 16 cycles; ctl_ready held 0 across 9 expiries -> refresh_overrun=1.
REQ-036 ctl_ready=0 for 5 cycles -> ctl_valid and ctl_addr stable; rst_n low while in WAIT -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and defaults for the DDR command arbiter.
// Refresh support is compiled in only when DDR_ARB_REFRESH_EN is defined.
`timescale 1ns/1ps
package ddr_pkg;
    localparam int DEF_ADDR_W      = 24;
    localparam int DEF_REFI_CYCLES = 1037;
    localparam int DEBT_MAX        = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {REQ_DISP, REQ_DRAW, REQ_REFRESH} req_id_t;
endpackage

// File: rtl/ddr_arbiter_if.sv
// Requester and DDR-controller handshake bundle; master is the arbiter side.
`timescale 1ns/1ps
interface ddr_arbiter_if #(parameter int ADDR_W = ddr_pkg::DEF_ADDR_W);
    logic              disp_req;
    logic              disp_urgent;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_done;
    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic              draw_gnt;
    logic              draw_done;
    logic              ctl_valid;
    logic              ctl_write;
    logic              ctl_refresh;
    logic [ADDR_W-1:0] ctl_addr;
    logic              ctl_ready;
    logic              ctl_done;

    modport master (
        input  disp_req, disp_urgent, disp_addr, draw_req, draw_addr, ctl_ready, ctl_done,
        output disp_gnt, disp_done, draw_gnt, draw_done, ctl_valid, ctl_write, ctl_refresh, ctl_addr
    );
    modport slave (
        output disp_req, disp_urgent, disp_addr, draw_req, draw_addr, ctl_ready, ctl_done,
        input  disp_gnt, disp_done, draw_gnt, draw_done, ctl_valid, ctl_write, ctl_refresh, ctl_addr
    );
endinterface

// File: rtl/ddr_refresh_timer.sv
// Refresh interval timer plus outstanding-refresh debt counter (0..DEBT_MAX).
// Used by ddr_arbiter only when DDR_ARB_REFRESH_EN is defined.
`timescale 1ns/1ps
module ddr_refresh_timer
    import ddr_pkg::*;
#(
    parameter int REFI_CYCLES = DEF_REFI_CYCLES
) (
    input  logic clk133,
    input  logic rst_n,
    input  logic accept,
    output logic pending,
    output logic overrun
);
    localparam int CNT_W = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFI_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       debt;
    logic             expire;

    assign expire  = (cnt == '0);
    assign pending = (debt != 4'd0);

    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= RELOAD;
            debt    <= 4'd0;
            overrun <= 1'b0;
        end else begin
            cnt <= expire ? RELOAD : cnt - 1'b1;
            // expiry and acceptance in the same cycle cancel out
            case ({expire, accept})
                2'b10: begin
                    if (debt == 4'(DEBT_MAX)) overrun <= 1'b1;
                    else                      debt    <= debt + 4'd1;
                end
                2'b01: if (debt != 4'd0) debt <= debt - 4'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ddr_arbiter.sv
// Display/draw/refresh arbiter issuing one command at a time to the DDR controller.
// Define DDR_ARB_REFRESH_EN to include periodic refresh generation and priority.
`timescale 1ns/1ps
module ddr_arbiter
    import ddr_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int REFI_CYCLES = DEF_REFI_CYCLES
) (
    input  logic          clk133,
    input  logic          rst_n,
    ddr_arbiter_if.master bus,
    output logic          busy,
    output logic          refresh_overrun
);
    state_t            state;
    req_id_t           owner;
    req_id_t           pick;
    logic              pick_vld;
    logic              rr_draw;
    logic              ref_pend;
    logic [ADDR_W-1:0] sel_addr;

    if (REFI_CYCLES < 2) begin : g_refi_chk
        $error("REFI_CYCLES must be at least 2");
    end

`ifdef DDR_ARB_REFRESH_EN
    logic ref_accept;
    assign ref_accept = (state == ISSUE) && bus.ctl_refresh && bus.ctl_ready;

    ddr_refresh_timer #(.REFI_CYCLES(REFI_CYCLES)) u_refresh (
        .clk133  (clk133),
        .rst_n   (rst_n),
        .accept  (ref_accept),
        .pending (ref_pend),
        .overrun (refresh_overrun)
    );
`else
    assign ref_pend        = 1'b0;
    assign refresh_overrun = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Refresh first, then urgent display, then round-robin.
    always_comb begin
        pick     = REQ_DISP;
        pick_vld = 1'b1;
        if (ref_pend)
            pick = REQ_REFRESH;
        else if (bus.disp_req && (bus.disp_urgent || !bus.draw_req || !rr_draw))
            pick = REQ_DISP;
        else if (bus.draw_req)
            pick = REQ_DRAW;
        else
            pick_vld = 1'b0;
        case (pick)
            REQ_DISP: sel_addr = bus.disp_addr;
            REQ_DRAW: sel_addr = bus.draw_addr;
            default:  sel_addr = '0;
        endcase
    end

    always_ff @(posedge clk133 or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            owner           <= REQ_DISP;
            rr_draw         <= 1'b0;
            bus.ctl_valid   <= 1'b0;
            bus.ctl_write   <= 1'b0;
            bus.ctl_refresh <= 1'b0;
            bus.ctl_addr    <= '0;
            bus.disp_gnt    <= 1'b0;
            bus.draw_gnt    <= 1'b0;
            bus.disp_done   <= 1'b0;
            bus.draw_done   <= 1'b0;
        end else begin
            bus.disp_gnt  <= 1'b0;
            bus.draw_gnt  <= 1'b0;
            bus.disp_done <= 1'b0;
            bus.draw_done <= 1'b0;
            case (state)
                IDLE: if (pick_vld) begin
                    owner           <= pick;
                    bus.ctl_valid   <= 1'b1;
                    bus.ctl_addr    <= sel_addr;
                    bus.ctl_write   <= (pick == REQ_DRAW);
                    bus.ctl_refresh <= (pick == REQ_REFRESH);
                    bus.disp_gnt    <= (pick == REQ_DISP);
                    bus.draw_gnt    <= (pick == REQ_DRAW);
                    state           <= ISSUE;
                end
                ISSUE: if (bus.ctl_ready) begin
                    bus.ctl_valid <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (bus.ctl_done) begin
                    bus.disp_done <= (owner == REQ_DISP);
                    bus.draw_done <= (owner == REQ_DRAW);
                    // refresh leaves the round-robin pointer untouched
                    if (owner == REQ_DISP)      rr_draw <= 1'b1;
                    else if (owner == REQ_DRAW) rr_draw <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
